frame_buffer_db: RTL

Parametrised, double-buffered frame store for a raster display. The renderer writes into a back bank while the display scan-out reads from a front bank. A swap request flips the banks on the next frame boundary, so the display never shows a partially drawn frame. A built-in clear engine fills the back bank with a programmable colour, one pixel per cycle. It sits between the pixel-generation pipeline and the video timing/scan-out logic.

---
 rtl/frame_buffer_pkg.sv | 19 +
 rtl/fb_bank.sv | 29 ++
 rtl/frame_buffer_db.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/frame_buffer_pkg.sv
// Shared types and defaults for the double-buffered frame store.
package frame_buffer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fb_state_e;

  localparam int DEF_H_RES = 1920;
  localparam int DEF_V_RES = 1080;
  localparam int DEF_PIX_W = 24;

  // Linear raster address of pixel (x, y) for a line width of h_res pixels.
  function automatic int unsigned lin_addr(input int unsigned x, input int unsigned y,
                                           input int unsigned h_res);
    return y * h_res + x;
  endfunction

endpackage

// File: rtl/fb_bank.sv
// One frame bank: simple dual-port RAM, one write port and one registered read port.
module fb_bank #(
  parameter int DEPTH = 8,
  parameter int PIX_W = 24,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  // No reset on the array or read register so the bank maps onto block RAM;
  // callers only present in-range addresses.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/frame_buffer_db.sv
// Double-buffered frame store: renderer writes the back bank, scan-out reads the front bank,
// banks swap only at a frame boundary, and a clear engine fills the back bank.
module frame_buffer_db
  import frame_buffer_pkg::*;
#(
  parameter int H_RES  = DEF_H_RES,
  parameter int V_RES  = DEF_V_RES,
  parameter int PIX_W  = DEF_PIX_W,
  parameter int DEPTH  = H_RES * V_RES,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  output logic              wr_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data,
  output logic              rd_valid,
  input  logic              frame_start,
  input  logic              swap_req,
  output logic              swap_done,
  input  logic              clear_req,
  input  logic [PIX_W-1:0]  clear_color,
  output logic              clear_done,
  output logic              front_sel
);

  // Handshakes: a write transfers on a cycle with wr_en && wr_ready; a read is
  // accepted on every rd_en cycle and answered by rd_valid/rd_data one cycle later.
  // swap_req, clear_req, frame_start, swap_done and clear_done are single-cycle pulses.

  localparam int                 BANK_AW = $clog2(DEPTH);
  localparam logic [ADDR_W:0]    DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [BANK_AW-1:0] LAST_A  = BANK_AW'(DEPTH - 1);

  fb_state_e          state_q, state_d;
  logic [BANK_AW-1:0] cnt_q;
  logic [PIX_W-1:0]   color_q;
  logic               clr_we;

  logic               pending_q;
  logic               front_q;
  logic               fire;
  logic               fire_q;
  logic               swap_done_q;
  logic               clear_done_q;

  logic               rd_valid_q;
  logic               rd_sel_q;
  logic               rd_zero_q;

  logic               wr_hit;
  logic               rd_hit;
  logic               bank_we_any;
  logic [1:0]         bank_we;
  logic [BANK_AW-1:0] bank_waddr;
  logic [PIX_W-1:0]   bank_wdata;
  logic [PIX_W-1:0]   rdata0;
  logic [PIX_W-1:0]   rdata1;

  assign wr_hit = ({1'b0, wr_addr} < DEPTH_L);
  assign rd_hit = ({1'b0, rd_addr} < DEPTH_L);

  // Clear engine FSM: next state and fill strobe.
  always_comb begin
    state_d = state_q;
    clr_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        clr_we = 1'b1;
        if (cnt_q == LAST_A) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      color_q      <= '0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clear_done_q <= (state_q == CLEAR) && (cnt_q == LAST_A);
      if ((state_q == IDLE) && clear_req) begin
        cnt_q   <= '0;
        color_q <= clear_color;
      end else if (state_q == CLEAR) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // A swap needs a frame boundary and an idle clear engine; otherwise it waits as pending.
  assign fire = frame_start && (pending_q || swap_req) && (state_q == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q   <= 1'b0;
      front_q     <= 1'b0;
      fire_q      <= 1'b0;
      swap_done_q <= 1'b0;
    end else begin
      if (fire) begin
        front_q   <= ~front_q;
        pending_q <= 1'b0;
      end else if (swap_req) begin
        pending_q <= 1'b1;
      end
      fire_q      <= fire;
      swap_done_q <= fire_q;
    end
  end

  // Both banks share one write path; only the back bank (~front_q) is enabled.
  assign bank_we_any = clr_we || ((state_q == IDLE) && wr_en && wr_hit);
  assign bank_waddr  = clr_we ? cnt_q : wr_addr[BANK_AW-1:0];
  assign bank_wdata  = clr_we ? color_q : wr_data;
  assign bank_we[0]  = bank_we_any && front_q;
  assign bank_we[1]  = bank_we_any && !front_q;

  fb_bank #(
    .DEPTH (DEPTH),
    .PIX_W (PIX_W),
    .AW    (BANK_AW)
  ) u_bank0 (
    .clk   (clk),
    .we    (bank_we[0]),
    .waddr (bank_waddr),
    .wdata (bank_wdata),
    .re    (rd_en && rd_hit),
    .raddr (rd_addr[BANK_AW-1:0]),
    .rdata (rdata0)
  );

  fb_bank #(
    .DEPTH (DEPTH),
    .PIX_W (PIX_W),
    .AW    (BANK_AW)
  ) u_bank1 (
    .clk   (clk),
    .we    (bank_we[1]),
    .waddr (bank_waddr),
    .wdata (bank_wdata),
    .re    (rd_en && rd_hit),
    .raddr (rd_addr[BANK_AW-1:0]),
    .rdata (rdata1)
  );

  // Bank select and out-of-range flag are captured with the read, so rd_data holds
  // between reads and reads zero after reset or for an out-of-range address.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_sel_q   <= 1'b0;
      rd_zero_q  <= 1'b1;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_sel_q  <= front_q;
        rd_zero_q <= !rd_hit;
      end
    end
  end

  assign rd_data    = rd_zero_q ? '0 : (rd_sel_q ? rdata1 : rdata0);
  assign rd_valid   = rd_valid_q;
  assign wr_ready   = (state_q == IDLE);
  assign swap_done  = swap_done_q;
  assign clear_done = clear_done_q;
  assign front_sel  = front_q;

endmodule
